// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control sequencer: opcodes, T-state
// encoding and instruction classes.
package cpu_ctrl_pkg;

  localparam int OPCODE_BITS = 5;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHL  = 5'b01000;
  localparam logic [4:0] OP_ROR  = 5'b01001;
  localparam logic [4:0] OP_ROL  = 5'b01010;
  localparam logic [4:0] OP_ADDI = 5'b01011;
  localparam logic [4:0] OP_ANDI = 5'b01100;
  localparam logic [4:0] OP_ORI  = 5'b01101;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    ST_RST, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALT
  } tstate_e;

  typedef enum logic [3:0] {
    CL_RTYPE, CL_ITYPE, CL_LD, CL_LDI, CL_ST, CL_MULDIV, CL_BR, CL_NOP, CL_HALT
  } opclass_e;

  // Immediate forms reuse the ALU code of their register-register sibling.
  function automatic logic [4:0] itype_alu_op(input logic [4:0] opc);
    case (opc)
      OP_ANDI: return OP_AND;
      OP_ORI:  return OP_OR;
      default: return OP_ADD;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_opclass_decode.sv
// Combinational opcode -> instruction-class decode; unknown opcodes fall to NOP.
module ctrl_opclass_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [4:0] i_opcode,
  output opclass_e   o_class
);

  always_comb begin
    o_class = CL_NOP;
    case (i_opcode)
      OP_LD:   o_class = CL_LD;
      OP_LDI:  o_class = CL_LDI;
      OP_ST:   o_class = CL_ST;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL:
               o_class = CL_RTYPE;
      OP_ADDI, OP_ANDI, OP_ORI:
               o_class = CL_ITYPE;
      OP_MUL, OP_DIV:
               o_class = CL_MULDIV;
      OP_BR:   o_class = CL_BR;
      OP_HALT: o_class = CL_HALT;
      default: o_class = CL_NOP;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired T-state control unit: fetch, decode IR[31:27], execute, back to T0.
// Strobes are a pure decode of (state, class, CON_FF); no strobe survives reset.
//
// state   | meaning
// RST     | held in reset, all strobes low
// T0..T2  | fetch (T1 is a memory read)
// T3..T7  | execute, per instruction class (LD T6 is a memory read)
// HALT    | stopped until reset
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 5,
  parameter int MEM_WAIT = 0
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic [31:0] IR,
  input  logic        CON_FF,
  output logic        PCout,
  output logic        Zlowout,
  output logic        ZHighout,
  output logic        MDRout,
  output logic        HIout,
  output logic        LOout,
  output logic        Cout,
  output logic        InPortout,
  output logic        MARin,
  output logic        Zin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        HIin,
  output logic        LOin,
  output logic        CONin,
  output logic        OutPortin,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  output logic        GRA,
  output logic        GRB,
  output logic        GRC,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic [4:0]  operation,
  output logic        Run
);

  tstate_e                r_state;
  tstate_e                w_state_nxt;
  logic [2:0]             r_wait_cnt;
  logic [2:0]             w_wait_nxt;
  logic [OPCODE_W-1:0]    w_opcode;
  logic [4:0]             w_op5;
  opclass_e               w_class;
  logic                   w_read_state;
  logic                   w_unused_ir;

  assign w_opcode    = IR[31 -: OPCODE_W];
  assign w_op5       = 5'(w_opcode);
  assign w_unused_ir = ^IR[31-OPCODE_W:0];

  ctrl_opclass_decode u_decode (
    .i_opcode (w_op5),
    .o_class  (w_class)
  );

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      r_state    <= ST_RST;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
    end
  end

  // Wait counter is a down-counter loaded on entry to a read state; the read
  // state is left only once it reaches zero, so it is clear on every exit.
  always_comb begin
    w_state_nxt  = r_state;
    w_wait_nxt   = '0;
    w_read_state = (r_state == ST_T1) || ((r_state == ST_T6) && (w_class == CL_LD));
    if (w_read_state && (r_wait_cnt != 3'd0)) begin
      w_wait_nxt = r_wait_cnt - 3'd1;
    end else begin
      case (r_state)
        ST_RST:  w_state_nxt = ST_T0;
        ST_T0: begin
          w_state_nxt = ST_T1;
          w_wait_nxt  = 3'(MEM_WAIT);
        end
        ST_T1:   w_state_nxt = ST_T2;
        ST_T2: begin
          case (w_class)
            CL_NOP:  w_state_nxt = ST_T0;
            CL_HALT: w_state_nxt = ST_HALT;
            default: w_state_nxt = ST_T3;
          endcase
        end
        ST_T3:   w_state_nxt = ST_T4;
        ST_T4:   w_state_nxt = ST_T5;
        ST_T5: begin
          case (w_class)
            CL_LD: begin
              w_state_nxt = ST_T6;
              w_wait_nxt  = 3'(MEM_WAIT);
            end
            CL_ST, CL_MULDIV, CL_BR: w_state_nxt = ST_T6;
            default:                 w_state_nxt = ST_T0;
          endcase
        end
        ST_T6:   w_state_nxt = ((w_class == CL_LD) || (w_class == CL_ST)) ? ST_T7 : ST_T0;
        ST_T7:   w_state_nxt = ST_T0;
        ST_HALT: w_state_nxt = ST_HALT;
        default: w_state_nxt = ST_RST;
      endcase
    end
  end

  always_comb begin
    PCout = 1'b0; Zlowout = 1'b0; ZHighout = 1'b0; MDRout = 1'b0;
    HIout = 1'b0; LOout = 1'b0; Cout = 1'b0; InPortout = 1'b0;
    MARin = 1'b0; Zin = 1'b0; PCin = 1'b0; MDRin = 1'b0; IRin = 1'b0;
    Yin = 1'b0; HIin = 1'b0; LOin = 1'b0; CONin = 1'b0; OutPortin = 1'b0;
    IncPC = 1'b0; Read = 1'b0; Write = 1'b0;
    GRA = 1'b0; GRB = 1'b0; GRC = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
    operation = 5'b00000;
    Run = (r_state != ST_RST) && (r_state != ST_HALT);
    case (r_state)
      ST_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
      ST_T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
      ST_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      ST_T3: begin
        case (w_class)
          CL_RTYPE, CL_ITYPE:   begin GRB = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          CL_LD, CL_LDI, CL_ST: begin GRB = 1'b1; BAout = 1'b1; Yin = 1'b1; end
          CL_MULDIV:            begin GRA = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          CL_BR:                begin GRA = 1'b1; Rout = 1'b1; CONin = 1'b1; end
          default: ;
        endcase
      end
      ST_T4: begin
        case (w_class)
          CL_RTYPE, CL_MULDIV: begin
            GRC = (w_class == CL_RTYPE); GRB = (w_class == CL_MULDIV);
            Rout = 1'b1; Zin = 1'b1; operation = w_op5;
          end
          CL_ITYPE:             begin Cout = 1'b1; Zin = 1'b1; operation = itype_alu_op(w_op5); end
          CL_LD, CL_LDI, CL_ST: begin Cout = 1'b1; Zin = 1'b1; operation = OP_ADD; end
          CL_BR:                begin PCout = 1'b1; Yin = 1'b1; end
          default: ;
        endcase
      end
      ST_T5: begin
        case (w_class)
          CL_RTYPE, CL_ITYPE, CL_LDI: begin Zlowout = 1'b1; GRA = 1'b1; Rin = 1'b1; end
          CL_LD, CL_ST:               begin Zlowout = 1'b1; MARin = 1'b1; end
          CL_MULDIV:                  begin Zlowout = 1'b1; LOin = 1'b1; end
          CL_BR:                      begin Cout = 1'b1; Zin = 1'b1; operation = OP_ADD; end
          default: ;
        endcase
      end
      ST_T6: begin
        case (w_class)
          CL_LD:     begin Read = 1'b1; MDRin = 1'b1; end
          CL_ST:     begin GRA = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
          CL_MULDIV: begin ZHighout = 1'b1; HIin = 1'b1; end
          CL_BR:     begin Zlowout = 1'b1; PCin = CON_FF; end
          default: ;
        endcase
      end
      ST_T7: begin
        case (w_class)
          CL_LD:   begin MDRout = 1'b1; GRA = 1'b1; Rin = 1'b1; end
          CL_ST:   Write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  a_single_bus_driver: assert property (@(posedge Clock) disable iff (!Reset_n)
    $onehot0({PCout, Zlowout, ZHighout, MDRout, HIout, LOout, Cout, InPortout, Rout, BAout}));

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench: each instruction is expanded into its expected per-cycle
// strobe list from the instruction tables and compared cycle by cycle.
module tb_control_sequencer;

  localparam int MW = 2;

  logic        Clock = 1'b0;
  logic        Reset_n;
  logic [31:0] IR;
  logic        CON_FF;
  logic PCout, Zlowout, ZHighout, MDRout, HIout, LOout, Cout, InPortout;
  logic MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, CONin, OutPortin;
  logic IncPC, Read, Write, GRA, GRB, GRC, Rin, Rout, BAout, Run;
  logic [4:0] operation;

  always #5 Clock = ~Clock;

  control_sequencer #(.OPCODE_W(5), .MEM_WAIT(MW)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .IR(IR), .CON_FF(CON_FF),
    .PCout(PCout), .Zlowout(Zlowout), .ZHighout(ZHighout), .MDRout(MDRout),
    .HIout(HIout), .LOout(LOout), .Cout(Cout), .InPortout(InPortout),
    .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin),
    .Yin(Yin), .HIin(HIin), .LOin(LOin), .CONin(CONin), .OutPortin(OutPortin),
    .IncPC(IncPC), .Read(Read), .Write(Write), .GRA(GRA), .GRB(GRB), .GRC(GRC),
    .Rin(Rin), .Rout(Rout), .BAout(BAout), .operation(operation), .Run(Run)
  );

  localparam logic [26:0] M_PCOUT = 27'd1 << 26, M_ZLOW  = 27'd1 << 25, M_ZHIGH = 27'd1 << 24;
  localparam logic [26:0] M_MDROUT = 27'd1 << 23, M_COUT = 27'd1 << 20, M_MARIN = 27'd1 << 18;
  localparam logic [26:0] M_ZIN   = 27'd1 << 17, M_PCIN  = 27'd1 << 16, M_MDRIN = 27'd1 << 15;
  localparam logic [26:0] M_IRIN  = 27'd1 << 14, M_YIN   = 27'd1 << 13, M_HIIN  = 27'd1 << 12;
  localparam logic [26:0] M_LOIN  = 27'd1 << 11, M_CONIN = 27'd1 << 10, M_INCPC = 27'd1 << 8;
  localparam logic [26:0] M_READ  = 27'd1 << 7,  M_WRITE = 27'd1 << 6,  M_GRA   = 27'd1 << 5;
  localparam logic [26:0] M_GRB   = 27'd1 << 4,  M_GRC   = 27'd1 << 3,  M_RIN   = 27'd1 << 2;
  localparam logic [26:0] M_ROUT  = 27'd1 << 1,  M_BAOUT = 27'd1 << 0;

  wire [32:0] w_obs = {PCout, Zlowout, ZHighout, MDRout, HIout, LOout, Cout, InPortout,
                       MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, CONin, OutPortin,
                       IncPC, Read, Write, GRA, GRB, GRC, Rin, Rout, BAout, operation, Run};

  int n_cmp = 0;
  int n_err = 0;
  logic [32:0] q_exp[$];
  logic [4:0]  legal_ops[19] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
                                  5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd18, 5'd26, 5'd26};

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [26:0] m, input logic [4:0] op, input int n, input logic run);
    for (int k = 0; k < n; k++) q_exp.push_back({m, op, run});
  endtask

  // Expected strobe list for one instruction, T0 up to its last execute state.
  task automatic build_model(input logic [31:0] ir, input logic con);
    int opc;
    opc = int'(ir[31:27]);
    q_exp.delete();
    push(M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 5'd0, 1, 1'b1);
    push(M_ZLOW | M_PCIN | M_READ | M_MDRIN, 5'd0, 1 + MW, 1'b1);
    push(M_MDROUT | M_IRIN, 5'd0, 1, 1'b1);
    if (opc >= 3 && opc <= 10) begin
      push(M_GRB | M_ROUT | M_YIN, 5'd0, 1, 1'b1);
      push(M_GRC | M_ROUT | M_ZIN, 5'(opc), 1, 1'b1);
      push(M_ZLOW | M_GRA | M_RIN, 5'd0, 1, 1'b1);
    end else if (opc >= 11 && opc <= 13) begin
      push(M_GRB | M_ROUT | M_YIN, 5'd0, 1, 1'b1);
      push(M_COUT | M_ZIN, (opc == 11) ? 5'd3 : (opc == 12) ? 5'd5 : 5'd6, 1, 1'b1);
      push(M_ZLOW | M_GRA | M_RIN, 5'd0, 1, 1'b1);
    end else if (opc <= 2) begin
      push(M_GRB | M_BAOUT | M_YIN, 5'd0, 1, 1'b1);
      push(M_COUT | M_ZIN, 5'd3, 1, 1'b1);
      if (opc == 1) push(M_ZLOW | M_GRA | M_RIN, 5'd0, 1, 1'b1);
      else begin
        push(M_ZLOW | M_MARIN, 5'd0, 1, 1'b1);
        if (opc == 0) begin
          push(M_READ | M_MDRIN, 5'd0, 1 + MW, 1'b1);
          push(M_MDROUT | M_GRA | M_RIN, 5'd0, 1, 1'b1);
        end else begin
          push(M_GRA | M_ROUT | M_MDRIN, 5'd0, 1, 1'b1);
          push(M_WRITE, 5'd0, 1, 1'b1);
        end
      end
    end else if (opc == 14 || opc == 15) begin
      push(M_GRA | M_ROUT | M_YIN, 5'd0, 1, 1'b1);
      push(M_GRB | M_ROUT | M_ZIN, 5'(opc), 1, 1'b1);
      push(M_ZLOW | M_LOIN, 5'd0, 1, 1'b1);
      push(M_ZHIGH | M_HIIN, 5'd0, 1, 1'b1);
    end else if (opc == 18) begin
      push(M_GRA | M_ROUT | M_CONIN, 5'd0, 1, 1'b1);
      push(M_PCOUT | M_YIN, 5'd0, 1, 1'b1);
      push(M_COUT | M_ZIN, 5'd3, 1, 1'b1);
      push(M_ZLOW | (con ? M_PCIN : 27'd0), 5'd0, 1, 1'b1);
    end else if (opc == 27) begin
      push(27'd0, 5'd0, 20, 1'b0);
    end
  endtask

  // Entered at a negedge with the DUT in T0; leaves at the negedge after the
  // instruction's last state (next T0, or still in HALT).
  task automatic run_instr(input logic [31:0] ir, input logic con, input string name);
    IR = ir;
    CON_FF = con;
    build_model(ir, con);
    foreach (q_exp[i]) begin
      chk($sformatf("%s cyc%0d", name, i), w_obs, q_exp[i]);
      @(negedge Clock);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] opc;
    Reset_n = 1'b0;
    IR = 32'h0;
    CON_FF = 1'b0;
    repeat (3) begin
      @(negedge Clock);
      chk("reset", w_obs, 33'd0);
    end
    Reset_n = 1'b1;
    @(negedge Clock);

    run_instr(32'h2A1B8000, 1'b0, "and_r4_r3_r7");
    run_instr({5'b00000, 27'h0123456}, 1'b0, "ld");
    run_instr({5'b00010, 27'h0456789}, 1'b1, "st");
    run_instr({5'b10010, 27'h0800000}, 1'b0, "br_nt");
    run_instr({5'b10010, 27'h0800000}, 1'b1, "br_t");
    run_instr({5'b10111, 27'h1234567}, 1'b0, "illegal");
    run_instr({5'b01110, 27'h0000000}, 1'b0, "mul");
    run_instr({5'b01100, 27'h7FFFFFF}, 1'b0, "andi");

    // Reset while an ADD sits in T4: strobes must drop and restart from T0.
    IR = {5'b00011, 27'h1111111};
    CON_FF = 1'b0;
    build_model(IR, 1'b0);
    for (int i = 0; i <= 4 + MW; i++) begin
      chk($sformatf("add_pre_rst cyc%0d", i), w_obs, q_exp[i]);
      if (i < 4 + MW) @(negedge Clock);
    end
    Reset_n = 1'b0;
    repeat (3) begin
      @(negedge Clock);
      chk("mid_instr_reset", w_obs, 33'd0);
    end
    Reset_n = 1'b1;
    @(negedge Clock);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        opc = 5'($urandom);
        if (opc == 5'b11011) opc = 5'b11100;
      end else begin
        opc = legal_ops[$urandom_range(0, 18)];
      end
      run_instr({opc, 27'($urandom)}, 1'($urandom_range(0, 1)), $sformatf("rnd%0d_op%0d", n, opc));
    end

    run_instr({5'b11011, 27'h0}, 1'b0, "halt");
    Reset_n = 1'b0;
    @(negedge Clock);
    chk("halt_reset", w_obs, 33'd0);
    Reset_n = 1'b1;
    @(negedge Clock);
    run_instr({5'b01011, 27'h2222222}, 1'b0, "addi_after_halt");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
